// File: rtl/ir_pkg.sv
// IR field layout, opcode constants and fetch FSM states shared by the core front end.
package ir_pkg;

  localparam int IR_W    = 32;
  localparam int OPER_HI = 31;
  localparam int OPER_LO = 27;
  localparam int RDST_HI = 26;
  localparam int RDST_LO = 22;
  localparam int RS1_HI  = 21;
  localparam int RS1_LO  = 17;
  localparam int IMM_BIT = 16;
  localparam int RS2_HI  = 15;
  localparam int RS2_LO  = 11;
  localparam int ISRC_HI = 15;
  localparam int ISRC_LO = 0;

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_HALT    = 5'd31;

  // rsrc2 overlaps the top of isrc; decode picks one by imm_mode.
  typedef struct packed {
    logic [4:0]  oper_type;
    logic [4:0]  rdst;
    logic [4:0]  rsrc1;
    logic        imm_mode;
    logic [15:0] isrc;
  } ir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  function automatic logic is_halt(input logic [IR_W-1:0] word);
    ir_t w_ir;
    w_ir = ir_t'(word);
    return w_ir.oper_type == OP_HALT;
  endfunction

endpackage

// File: rtl/ir_fetch_buf.sv
// Two-entry IR skid FIFO; head is visible combinationally, zero-latency pop.
// Caller guarantees no push when full unless popping; flush empties in one cycle.
module ir_fetch_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push_vld,
  input  logic [DATA_W-1:0] i_push_dat,
  input  logic [ADDR_W-1:0] i_push_pc,
  input  logic              i_pop,
  output logic              o_head_vld,
  output logic [DATA_W-1:0] o_head_dat,
  output logic [ADDR_W-1:0] o_head_pc,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_dat [2];
  logic [ADDR_W-1:0] r_pc  [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic w_pop;
  logic w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push_vld && ((r_count != 2'd2) || w_pop);

  assign o_head_vld = (r_count != 2'd0);
  assign o_head_dat = r_dat[r_rd_ptr];
  assign o_head_pc  = r_pc[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dat[0] <= '0;
      r_dat[1] <= '0;
      r_pc[0]  <= '0;
      r_pc[1]  <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_dat[r_wr_ptr] <= i_push_dat;
        r_pc[r_wr_ptr]  <= i_push_pc;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule

// File: rtl/ir_fetch_unit.sv
// Fetch front end: PC, read issue and IDLE/RUN/HALTED control; first IR 2 cycles after start, then 1/cycle.
// Stalls issue when buffer + in-flight would exceed 2; redirect/halt flush and drop the in-flight return.
module ir_fetch_unit
  import ir_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_word,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              halted
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic              r_halted;

  logic       w_run;
  logic       w_pop;
  logic       w_redir;
  logic       w_halt_acc;
  logic       w_flush;
  logic       w_push;
  logic       w_issue;
  logic [1:0] w_count;
  logic [2:0] w_occ;

  assign w_run      = (r_state == RUN);
  assign w_pop      = w_run && ir_valid && ir_ready;
  assign w_redir    = w_run && redir_valid;
  assign w_halt_acc = w_pop && !w_redir && is_halt(ir_word);
  assign w_flush    = w_redir || w_halt_acc;
  // Data returning in a flush cycle belongs to the abandoned stream.
  assign w_push     = r_inflight && !w_flush;
  assign w_occ      = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue    = w_run && !w_flush && (w_occ < 3'd2);

  assign imem_rd_en = w_issue;
  assign imem_addr  = r_pc;
  assign halted     = r_halted;

  ir_fetch_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (w_flush),
    .i_push_vld (w_push),
    .i_push_dat (imem_rdata),
    .i_push_pc  (r_inflight_pc),
    .i_pop      (w_pop),
    .o_head_vld (ir_valid),
    .o_head_dat (ir_word),
    .o_head_pc  (ir_pc),
    .o_count    (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_halted      <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
      end
      case (r_state)
        IDLE, HALTED: begin
          if (start) begin
            r_state  <= RUN;
            r_pc     <= start_pc;
            r_halted <= 1'b0;
          end
        end
        RUN: begin
          if (w_redir) begin
            r_pc <= redir_pc;
          end else if (w_halt_acc) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end else if (w_issue) begin
            r_pc <= r_pc + ADDR_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Fetch unit bench: stream-level reference model checked every cycle, plus directed latency/halt/wrap/reset cases.
module tb_ir_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  start_pc;
  logic        imem_rd_en;
  logic [3:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_word;
  logic [3:0]  ir_pc;
  logic        redir_valid;
  logic [3:0]  redir_pc;
  logic        halted;

  logic [31:0] mem [16];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rd_cnt   = 0;

  ir_fetch_unit #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_pc    (start_pc),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_word     (ir_word),
    .ir_pc       (ir_pc),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .halted      (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic word_is_halt(input logic [31:0] w);
    return w[31:27] == 5'd31;
  endfunction

  // Stream model: the presented word is always the next one the program order calls for.
  int         m_st = 0;   // 0 idle, 1 running, 2 halted
  logic [3:0] m_pc = '0;
  logic [3:0] m_fetch = '0;
  int         m_out = 0;
  bit         m_clear = 0;
  bit         m_hold = 0;

  always @(negedge clk) begin
    bit acc;
    if (!rst_n) begin
      chk("rst_ir_valid", ir_valid, 0);
      chk("rst_rd_en", imem_rd_en, 0);
      chk("rst_halted", halted, 0);
      m_st = 0; m_out = 0; m_clear = 0; m_hold = 0;
    end else begin
      acc = ir_valid && ir_ready;
      if (imem_rd_en) rd_cnt++;
      chk("halted", halted, m_st == 2);
      if (m_st != 1) begin
        chk("idle_valid", ir_valid, 0);
        chk("idle_rd_en", imem_rd_en, 0);
      end else begin
        if (m_clear) chk("valid_after_flush", ir_valid, 0);
        if (m_hold) chk("held_valid", ir_valid, 1);
        if (ir_valid) begin
          chk("ir_pc", ir_pc, m_pc);
          chk("ir_word", ir_word, mem[m_pc]);
        end
        if (redir_valid) chk("rd_on_redir", imem_rd_en, 0);
        if (imem_rd_en) begin
          chk("rd_addr", imem_addr, m_fetch);
          chk("overfetch", (m_out - int'(acc)) < 2, 1);
        end
      end
      m_clear = 0;
      m_hold  = 0;
      if (m_st == 1) begin
        if (redir_valid) begin
          m_pc = redir_pc; m_fetch = redir_pc; m_out = 0; m_clear = 1;
        end else if (acc && word_is_halt(mem[m_pc])) begin
          m_st = 2; m_out = 0;
        end else begin
          if (acc) begin m_pc = m_pc + 4'd1; m_out--; end
          if (imem_rd_en) begin m_fetch = m_fetch + 4'd1; m_out++; end
          m_hold = ir_valid && !ir_ready;
        end
      end else if (start) begin
        m_st = 1; m_pc = start_pc; m_fetch = start_pc; m_out = 0; m_clear = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] pc);
    step();
    start = 1'b1;
    start_pc = pc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_halted(input string name);
    for (int i = 0; i < 40; i++) begin
      if (halted) break;
      step();
    end
    #3;
    chk(name, halted, 1);
  endtask

  initial begin
    int rd_base;
    rst_n = 1'b0; start = 1'b0; start_pc = '0; ir_ready = 1'b0;
    redir_valid = 1'b0; redir_pc = '0;
    mem[0] = 32'h1044_1800;
    mem[1] = 32'h1083_0005;
    mem[2] = 32'h10C2_1000;
    mem[3] = 32'h1109_0007;
    mem[4] = 32'hF800_0000;
    for (int i = 5; i < 16; i++) mem[i] = 32'h0800_0000 | 32'(i);
    #2;
    chk("reset_valid", ir_valid, 0);
    chk("reset_rd_en", imem_rd_en, 0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_word", ir_word, 0);
    chk("reset_pc", ir_pc, 0);
    chk("reset_halted", halted, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Latency and sequential stream, ending on the HALT at address 4.
    ir_ready = 1'b1;
    do_start(4'd0);
    #3 chk("t1_rd_en_c0", imem_rd_en, 1); chk("t1_addr_c0", imem_addr, 0); chk("t1_valid_c0", ir_valid, 0);
    step(); #3 chk("t1_valid_c1", ir_valid, 0);
    step(); #3 chk("t1_valid_c2", ir_valid, 1); chk("t1_pc0", ir_pc, 0); chk("t1_w0", ir_word, 32'h1044_1800);
    step(); #3 chk("t1_pc1", ir_pc, 1); chk("t1_w1", ir_word, 32'h1083_0005);
    step(); #3 chk("t1_pc2", ir_pc, 2); chk("t1_w2", ir_word, 32'h10C2_1000);
    step(); #3 chk("t1_pc3", ir_pc, 3); chk("t1_w3", ir_word, 32'h1109_0007);
    step(); #3 chk("t1_pc4", ir_pc, 4); chk("t1_w4", ir_word, 32'hF800_0000);
    step(); #3 chk("t1_halted", halted, 1); chk("t1_h_valid", ir_valid, 0); chk("t1_h_rd", imem_rd_en, 0);
    step(); #3 chk("t1_h_rd2", imem_rd_en, 0);

    // Backpressure: five stalled cycles on the first word.
    ir_ready = 1'b0;
    rd_base = rd_cnt;
    do_start(4'd0);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      #3 chk("t2_stall_valid", ir_valid, 1); chk("t2_stall_pc", ir_pc, 0); chk("t2_stall_w", ir_word, 32'h1044_1800);
      step();
    end
    chk("t2_reads_le2", (rd_cnt - rd_base) <= 2, 1);
    ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3 chk("t2_rel_valid", ir_valid, 1); chk("t2_rel_pc", ir_pc, 4'(i));
      step();
    end
    wait_halted("t2_halt");

    // Redirect to 9 while the read of address 3 returns.
    do_start(4'd0);
    step(); step(); step(); step();
    redir_valid = 1'b1; redir_pc = 4'd9;
    #3 chk("t3_pc_at_redir", ir_pc, 2); chk("t3_no_rd", imem_rd_en, 0);
    step(); redir_valid = 1'b0;
    #3 chk("t3_valid_r1", ir_valid, 0); chk("t3_rd_r1", imem_rd_en, 1); chk("t3_addr_r1", imem_addr, 9);
    step(); #3 chk("t3_valid_r2", ir_valid, 0);
    step(); #3 chk("t3_valid_r3", ir_valid, 1); chk("t3_pc9", ir_pc, 9);
    step(); #3 chk("t3_pc10", ir_pc, 10);
    redir_valid = 1'b1; redir_pc = 4'd4;
    step(); redir_valid = 1'b0;
    wait_halted("t3_halt");

    // PC wrap.
    do_start(4'd15);
    step(); step();
    #3 chk("t4_pc15", ir_pc, 15);
    step(); #3 chk("t4_pc0", ir_pc, 0);
    step(); #3 chk("t4_pc1", ir_pc, 1);
    wait_halted("t4_halt");

    // Randomised stream against the model.
    for (int i = 0; i < 16; i++)
      mem[i] = {(($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 4))), 27'($urandom)};
    for (int c = 0; c < 3000; c++) begin
      step();
      ir_ready    = ($urandom_range(0, 3) != 0);
      redir_valid = ($urandom_range(0, 19) == 0);
      redir_pc    = 4'($urandom_range(0, 15));
      start       = ($urandom_range(0, 5) == 0);
      start_pc    = 4'($urandom_range(0, 15));
    end
    step();
    start = 1'b0; redir_valid = 1'b0; ir_ready = 1'b0;

    // Async reset with a word presented.
    mem[4] = 32'h0800_0004;
    for (int i = 0; i < 40; i++) begin
      if (ir_valid) break;
      start = !halted ? 1'b0 : 1'b1;
      if (m_st == 0) start = 1'b1;
      start_pc = 4'd0;
      step();
    end
    start = 1'b0;
    chk("t6_valid_before_rst", ir_valid, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", ir_valid, 0);
    chk("t6_rd_en", imem_rd_en, 0);
    chk("t6_addr", imem_addr, 0);
    chk("t6_word", ir_word, 0);
    chk("t6_pc", ir_pc, 0);
    chk("t6_halted", halted, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    ir_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      #3 chk("t6_post_valid", ir_valid, 0); chk("t6_post_rd", imem_rd_en, 0);
    end
    do_start(4'd5);
    step(); step();
    #3 chk("t6_restart_pc", ir_pc, 5);
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_fetch_unit.md
Name: ir_fetch_unit

Overview:
- Instruction fetch front end for the single-cycle core: reads 32-bit instruction words from a synchronous program memory and delivers them as IR words to the execute stage over a valid/ready handshake.
- Owns the program counter and handles sequential increment, redirects (jumps) from execute, and stop-on-HALT.
- It is the producer of IR words; the core's decode/execute logic is the consumer.

Parameters:
- ADDR_W, 4, program memory address width; PC wraps modulo 2**ADDR_W.
- DATA_W, 32, instruction width; fixed by the IR format.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; loads start_pc and begins fetching. Honoured only in IDLE or HALTED.
- start_pc  in  ADDR_W  first fetch address on start.
- imem_rd_en  out  1  memory read strobe.
- imem_addr  out  ADDR_W  memory read address.
- imem_rdata  in  DATA_W  read data, valid exactly 1 cycle after imem_rd_en.
- ir_valid  out  1  ir_word/ir_pc hold a valid instruction.
- ir_ready  in  1  consumer accepts when ir_valid && ir_ready.
- ir_word  out  DATA_W  instruction word.
- ir_pc  out  ADDR_W  address the word was fetched from.
- redir_valid  in  1  single-cycle redirect request from execute.
- redir_pc  in  ADDR_W  redirect target.
- halted  out  1  high in HALTED state.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pc=0; buffer empty; in-flight=0.
  - Outputs: imem_rd_en=0, imem_addr=0, ir_valid=0, ir_word=0, ir_pc=0, halted=0.
- States:
  - IDLE: start -> RUN, pc<=start_pc.
  - RUN: fetch. An accepted word with oper_type==OP_HALT -> HALTED.
  - HALTED: start -> RUN, pc<=start_pc.
- Buffer: 2-entry FIFO (head drives ir_word/ir_pc). ir_valid = head occupied.
- Read issue:
  - In RUN, issue (imem_rd_en=1, imem_addr=pc, pc<=pc+1 mod 2**ADDR_W) when occupancy + inflight - pop < 2, where pop = ir_valid && ir_ready.
  - Returning data is pushed 1 cycle later tagged with its address.
  - Steady state with ir_ready=1: one instruction per cycle after a 2-cycle initial latency (start at cycle 0, ir_valid at cycle 2).
  - The buffer never overflows; ir_word/ir_pc stay stable while ir_valid && !ir_ready.
- Redirect (redir_valid in RUN):
  - Flush both entries.
  - Mark any in-flight return as discard; it is not pushed.
  - pc<=redir_pc; no read is issued that cycle.
  - ir_valid=0 next cycle; the first fetch from redir_pc occurs next cycle.
  - A pop in the same cycle is still a valid accept.
  - redir_valid outside RUN is ignored.
- Halt:
  - On accept of a HALT word: flush, discard in-flight, stop issuing, halted=1 from the next cycle.
  - Redirect in the same cycle takes priority: stay in RUN and apply the redirect.
- start while in RUN is ignored.
- PC wrap: pc=2**ADDR_W-1 increments to 0; no error.
- Reset mid-operation: everything returns to reset values immediately. Any in-flight memory data arriving after reset release is ignored, because in-flight is cleared.

Decomposition:
- Shared package ir_pkg:
  - IR field ranges: oper_type [31:27], rdst [26:22], rsrc1 [21:17], imm_mode [16], rsrc2 [15:11], isrc [15:0].
  - Opcode constants: OP_MOVSGPR=0, OP_MOV=1, OP_ADD=2, OP_SUB=3, OP_MUL=4, OP_HALT=5'd31.
  - State enum {IDLE, RUN, HALTED}.
- One sub-module, ir_fetch_buf: 2-entry FIFO with flush, push, pop, count.
- PC, issue logic and FSM stay in the top module.

Test Plan:
- Reset, then start with start_pc=0; memory holds ADD/ADI words at 0..3; ir_ready=1 -> ir_valid rises at cycle 2; ir_pc sequence 0,1,2,3 on consecutive cycles; ir_word matches memory.
- Backpressure: hold ir_ready=0 for 5 cycles after the first valid -> ir_pc=0 and ir_word stay stable; at most 2 reads are issued; release gives 1,2,3 with no loss or duplicate.
- Redirect: pulse redir_valid with redir_pc=9 while a read of address 3 is in flight -> address-3 data is never presented; next valid ir_pc=9, then 10.
- Halt: word at address 4 has oper_type=31 -> after its accept, halted=1, imem_rd_en stays 0, ir_valid=0; a start pulse with start_pc=0 resumes at ir_pc=0.
- Wrap: start_pc=15 with ADDR_W=4 -> ir_pc sequence 15,0,1.
- Async reset asserted mid-stream with ir_valid=1 -> all outputs reach reset values without waiting for a clock edge; after release, no stale word appears until start.
